// File: rtl/ram_dp_sync_if.sv
// ram_dp_sync_if -- bus bundle between the RAM and its write/read agents.
//
// Signals:
//   write, wr_address, data_in   write request, address and data
//   read, rd_address             read request and address
//   data_out, rd_valid           registered read data and its valid flag
//   init_done                    clear sweep finished, ports are live
//
// master : the agent side (drives requests, observes results)
// slave  : the RAM side
interface ram_dp_sync_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
);
    logic                  write;
    logic [ADDR_WIDTH-1:0] wr_address;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  read;
    logic [ADDR_WIDTH-1:0] rd_address;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  init_done;

    modport master (
        output write, wr_address, data_in, read, rd_address,
        input  data_out, rd_valid, init_done
    );

    modport slave (
        input  write, wr_address, data_in, read, rd_address,
        output data_out, rd_valid, init_done
    );
endinterface

// File: rtl/ram_dp_sync.sv
// ram_dp_sync -- synchronous simple-dual-port RAM with a post-reset clear sweep.
//
// After reset the block walks every address writing zero (INIT), then raises
// init_done and accepts one write and one read per cycle (READY). Reads are
// registered with one cycle of latency; a read and write to the same address
// on the same edge return the new write data (write-first).
//
// Ports:
//   i_clock   single clock, rising edge
//   i_resetn  asynchronous active-low reset
//   bus       ram_dp_sync_if slave modport (requests in, read data/status out)
module ram_dp_sync #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic          i_clock,
    input  logic          i_resetn,
    ram_dp_sync_if.slave  bus
);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_rd_valid;
    logic                  r_init_done;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_collide;

    // During INIT the sweep owns the write port; user requests are dropped.
    always_comb begin
        w_we      = 1'b0;
        w_wr_addr = r_count;
        w_wr_data = '0;
        if (r_state == ST_INIT) begin
            w_we = 1'b1;
        end else begin
            w_we      = (bus.write == 1'b1);
            w_wr_addr = bus.wr_address;
            w_wr_data = bus.data_in;
        end
    end

    assign w_collide = (bus.write == 1'b1) && (bus.wr_address == bus.rd_address);

    // Storage array has no reset; the sweep is what clears it.
    always_ff @(posedge i_clock) begin
        if (w_we) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= ST_INIT;
            r_count     <= '0;
            r_data_out  <= '0;
            r_rd_valid  <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rd_valid <= 1'b0;
                    // Counter wraps to 0 naturally on the last address.
                    r_count    <= r_count + ADDR_WIDTH'(1);
                    if (r_count == ADDR_WIDTH'(DEPTH - 1)) begin
                        r_state     <= ST_READY;
                        r_init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.read == 1'b1) begin
                        r_rd_valid <= 1'b1;
                        r_data_out <= w_collide ? bus.data_in : r_mem[bus.rd_address];
                    end else begin
                        r_rd_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.init_done = r_init_done;

endmodule

// File: tb/tb_ram_dp_sync.sv
`timescale 1ns/1ps
module tb_ram_dp_sync;
    localparam int DW    = 64;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_dp_sync_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_dp_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .i_clock  (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain array of words plus the expected output registers.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_dout;
    logic          exp_valid;
    bit            model_ready;

    task automatic drive_idle();
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.wr_address = '0;
        bus.rd_address = '0;
        bus.data_in    = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        exp_dout    = '0;
        exp_valid   = 1'b0;
        model_ready = 1'b0;
    endtask

    // Predict the effect of the current inputs, then advance one edge.
    task automatic cycle();
        if (model_ready) begin
            if (bus.read) begin
                exp_valid = 1'b1;
                if (bus.write && bus.wr_address == bus.rd_address) exp_dout = bus.data_in;
                else                                                exp_dout = model[bus.rd_address];
            end else begin
                exp_valid = 1'b0;
            end
            if (bus.write) model[bus.wr_address] = bus.data_in;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs the DEPTH-edge clear sweep with whatever inputs are being driven.
    task automatic run_sweep(input string tag);
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            checks++;
            if (bus.rd_valid !== 1'b0) begin
                errors++;
                if (errors < 20) $display("FAIL %s sweep rd_valid edge %0d: got %b want 0", tag, i, bus.rd_valid);
            end
            checks++;
            if (bus.data_out !== '0) begin
                errors++;
                if (errors < 20) $display("FAIL %s sweep data_out edge %0d: got %h want 0", tag, i, bus.data_out);
            end
            checks++;
            if (bus.init_done !== (i == DEPTH)) begin
                errors++;
                if (errors < 20) $display("FAIL %s sweep init_done edge %0d: got %b want %b", tag, i, bus.init_done, (i == DEPTH));
            end
        end
        model_ready = 1'b1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] addrs [3];
        drive_idle();
        hold_reset();
        checks++;
        if (bus.data_out !== '0 || bus.rd_valid !== 1'b0 || bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got dout=%h valid=%b done=%b want 0/0/0", bus.data_out, bus.rd_valid, bus.init_done);
        end
        run_sweep("reset");
        addrs[0] = 12'h000; addrs[1] = 12'h7FF; addrs[2] = 12'hFFF;
        for (int k = 0; k < 3; k++) begin
            bus.read = 1'b1;
            bus.rd_address = addrs[k];
            cycle();
            checks++;
            if (bus.data_out !== 64'h0 || bus.rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL post_clear_read addr %h: got dout=%h valid=%b want 0/1", addrs[k], bus.data_out, bus.rd_valid);
            end
        end
        drive_idle();
        cycle();
    endtask

    task automatic test_basic();
        bus.write = 1'b1; bus.wr_address = 12'h0A5; bus.data_in = 64'hDEAD_BEEF_0123_4567;
        cycle();
        bus.wr_address = 12'hFFF; bus.data_in = 64'h0000_0000_0000_0001;
        cycle();
        bus.write = 1'b0;
        bus.read = 1'b1; bus.rd_address = 12'h0A5;
        cycle();
        checks++;
        if (bus.data_out !== 64'hDEAD_BEEF_0123_4567 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_read_0A5: got dout=%h valid=%b want deadbeef01234567/1", bus.data_out, bus.rd_valid);
        end
        bus.rd_address = 12'hFFF;
        cycle();
        checks++;
        if (bus.data_out !== 64'h1 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_read_FFF: got dout=%h valid=%b want 1/1", bus.data_out, bus.rd_valid);
        end
        bus.read = 1'b0;
        cycle();
        checks++;
        if (bus.data_out !== 64'h1 || bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got dout=%h valid=%b want 1/0", bus.data_out, bus.rd_valid);
        end
    endtask

    task automatic test_collision();
        drive_idle();
        bus.write = 1'b1; bus.wr_address = 12'h010; bus.data_in = 64'h1111;
        cycle();
        bus.data_in = 64'h2222;
        bus.read = 1'b1; bus.rd_address = 12'h010;
        cycle();
        checks++;
        if (bus.data_out !== 64'h2222 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL collision_bypass: got dout=%h valid=%b want 2222/1", bus.data_out, bus.rd_valid);
        end
        bus.write = 1'b0;
        cycle();
        checks++;
        if (bus.data_out !== 64'h2222 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL collision_stored: got dout=%h valid=%b want 2222/1", bus.data_out, bus.rd_valid);
        end
        drive_idle();
        cycle();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 10000; n++) begin
            bus.write = 1'($urandom_range(0, 1));
            bus.read  = 1'($urandom_range(0, 1));
            // Half the traffic on a tiny address window to force collisions.
            if ($urandom_range(0, 1) == 0) begin
                bus.wr_address = AW'($urandom_range(0, 15));
                bus.rd_address = AW'($urandom_range(0, 15));
            end else begin
                bus.wr_address = AW'($urandom);
                bus.rd_address = AW'($urandom);
            end
            bus.data_in = {$urandom, $urandom};
            cycle();
            checks++;
            if (bus.rd_valid !== exp_valid || bus.data_out !== exp_dout) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random cycle %0d: got dout=%h valid=%b want %h/%b", n, bus.data_out, bus.rd_valid, exp_dout, exp_valid);
            end
        end
        drive_idle();
        cycle();
    endtask

    task automatic test_init_ignored();
        bus.write = 1'b1; bus.wr_address = 12'h020; bus.data_in = 64'hFFFF;
        bus.read = 1'b1;  bus.rd_address = 12'h020;
        hold_reset();
        run_sweep("init_ignored");
        drive_idle();
        bus.read = 1'b1; bus.rd_address = 12'h020;
        cycle();
        checks++;
        if (bus.data_out !== 64'h0 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL init_ignored_read: got dout=%h valid=%b want 0/1", bus.data_out, bus.rd_valid);
        end
        drive_idle();
        cycle();
    endtask

    task automatic test_reset_mid();
        bus.write = 1'b1; bus.wr_address = 12'h100; bus.data_in = 64'hABCD;
        cycle();
        bus.write = 1'b0;
        bus.read = 1'b1; bus.rd_address = 12'h100;
        cycle();
        checks++;
        if (bus.data_out !== 64'hABCD || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_burst_read: got dout=%h valid=%b want abcd/1", bus.data_out, bus.rd_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== '0 || bus.rd_valid !== 1'b0 || bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got dout=%h valid=%b done=%b want 0/0/0", bus.data_out, bus.rd_valid, bus.init_done);
        end
        hold_reset();
        run_sweep("reset_mid");
        bus.read = 1'b1; bus.rd_address = 12'h100;
        cycle();
        checks++;
        if (bus.data_out !== 64'h0 || bus.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_cleared: got dout=%h valid=%b want 0/1", bus.data_out, bus.rd_valid);
        end
        drive_idle();
        cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        drive_idle();
        test_reset();
        test_basic();
        test_collision();
        test_random();
        test_init_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_dp_sync.md
# ram_dp_sync

Synchronous simple-dual-port RAM: the design under test for the dual-port RAM testbench. It has one write port and one read port on a single clock, a registered read with a valid flag, and write-first bypass on address collision. After reset it runs a hardware clear sweep, so every location reads as zero once it reports ready. It sits between the write agent and the read agent of the RAM environment and is the storage end of their protocol.

## Interface
- DATA_WIDTH, 64, width of data_in / data_out
- ADDR_WIDTH, 12, width of wr_address / rd_address
- DEPTH, 4096, number of words; must equal 2**ADDR_WIDTH
- clock  input  1  single clock; all state changes on the rising edge
- resetn  input  1  asynchronous, active-low reset
- write  input  1  write request, sampled on the rising edge
- wr_address  input  ADDR_WIDTH  write address
- data_in  input  DATA_WIDTH  write data
- read  input  1  read request, sampled on the rising edge
- rd_address  input  ADDR_WIDTH  read address
- data_out  output  DATA_WIDTH  registered read data
- rd_valid  output  1  data_out was updated by a read on the last edge
- init_done  output  1  clear sweep complete; ports are live

## Operation
- States: INIT and READY. Reset forces INIT and clears the sweep counter (ADDR_WIDTH bits) to 0.
- INIT behaviour:
  - Each rising edge writes 0 to mem[counter], then increments the counter.
  - On the edge that clears address DEPTH-1, the counter wraps to 0, the state moves to READY and init_done is set to 1.
  - write and read are ignored. rd_valid stays 0 and data_out holds 0.
- READY, write: write=1 stores data_in at mem[wr_address] on the edge.
- READY, read:
  - read=1 loads data_out and sets rd_valid=1 on the edge.
  - read=0 clears rd_valid to 0 on the edge and data_out holds its last value.
- Collision: write=1, read=1 and wr_address==rd_address on the same edge. The read is write-first: data_out takes that cycle's data_in, and memory is also updated.
- Read and write to different addresses on the same edge are independent and need no stall.
- No address range check is needed because DEPTH equals 2**ADDR_WIDTH. An X/Z request input is treated as 0 in READY; the bench never drives X.
- Reset mid-operation, in either state:
  - data_out goes to 0 and rd_valid and init_done go to 0 immediately.
  - The block returns to INIT and the clear sweep restarts from address 0.
  - Partially cleared or previously written contents are all zero after the new sweep.

## Timing
- Reset values: data_out=0, rd_valid=0, init_done=0, state INIT, counter 0.
- Clear sweep: edges 1..DEPTH after resetn rises (4096 edges by default).
  - init_done goes high after edge DEPTH.
  - The first accepted write or read is at edge DEPTH+1.
- Read latency is 1 cycle. With read=1 at edge N, data_out and rd_valid=1 are visible after edge N.
- Back-to-back reads on consecutive edges give consecutive data with rd_valid held high.
- Write then read of the same address on the next edge returns the new data, with no extra turnaround cycle.
- Throughput is one write and one read per cycle in READY.
- resetn deassertion is assumed synchronous to clock at block level; the synchronizer belongs to the top level.

## Test plan
- Reset then idle:
  - data_out=0 and rd_valid=0 throughout.
  - init_done=0 through edge 4095 and 1 after edge 4096.
  - read of addr 0x000, 0x7FF and 0xFFF then returns 0 with rd_valid=1.
- Basic write/read:
  - Write 0xDEAD_BEEF_0123_4567 to 0x0A5 and 0x0000_0000_0000_0001 to 0xFFF.
  - Read 0x0A5 then 0xFFF on consecutive edges: the two values appear on consecutive cycles with rd_valid=1 on both.
  - Next cycle read=0: rd_valid=0 and data_out holds 0x...0001.
- Collision: preload 0x010=0x1111; in one cycle write 0x2222 to 0x010 and read 0x010.
  - data_out=0x2222.
  - A read of 0x010 the next cycle also returns 0x2222.
- Ignored during INIT: drive write=1 to 0x020 with 0xFFFF and read=1 for the whole sweep.
  - rd_valid stays 0.
  - After init_done, a read of 0x020 returns 0.
- Reset mid-operation:
  - Write 0xABCD to 0x100, then pulse resetn low for 2 cycles during a read burst.
  - data_out, rd_valid and init_done go to 0 asynchronously.
  - A new 4096-cycle sweep runs, and a read of 0x100 returns 0.
- Random concurrent traffic: 10000 cycles of random write/read/address once READY, compared against a reference model with write-first collision. Zero mismatches are required.
